// File: rtl/morse_pkg.sv
// Shared Morse definitions for the transmit and decode paths.
// Contents: FSM state encoding, timing constants in Morse units,
// empty/space character codes and the character LUT result struct.
package morse_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        MARK,
        SGAP,
        CGAP,
        WGAP,
        DONE
    } state_t;

    localparam logic [7:0] CHAR_EMPTY = 8'hFF;
    localparam logic [7:0] CHAR_SPACE = 8'h20;

    localparam int unsigned DOT_UNITS  = 1;
    localparam int unsigned DASH_UNITS = 3;
    localparam int unsigned SGAP_UNITS = 1;
    localparam int unsigned CGAP_UNITS = 3;
    localparam int unsigned WGAP_UNITS = 4;

    // pattern is left-aligned: the first symbol sits in bit 4, 1 = dash.
    typedef struct packed {
        logic       valid;
        logic       is_space;
        logic [2:0] len;
        logic [4:0] pattern;
    } lut_res_t;

    function automatic lut_res_t mk_sym(input logic [2:0] len, input logic [4:0] pat);
        lut_res_t r;
        r.valid    = 1'b1;
        r.is_space = 1'b0;
        r.len      = len;
        r.pattern  = pat;
        return r;
    endfunction

endpackage

// File: rtl/morse_lut.sv
// ASCII to Morse symbol lookup (combinational).
// Ports:
//   ch  in  8   ASCII character (8'hFF = empty slot)
//   res out     lut_res_t: valid, is_space, len (1-5), left-aligned pattern
// Lowercase letters are folded onto uppercase. Anything outside A-Z, a-z,
// 0-9 and space returns valid = 0.
module morse_lut
    import morse_pkg::*;
(
    input  logic [7:0] ch,
    output lut_res_t   res
);

    logic [7:0] up;

    always_comb begin
        up = ch;
        if (ch >= 8'h61 && ch <= 8'h7A) begin
            up = ch - 8'h20;
        end
    end

    always_comb begin
        res = '0;
        case (up)
            CHAR_EMPTY: res = '0;
            CHAR_SPACE: begin
                res.valid    = 1'b1;
                res.is_space = 1'b1;
            end
            8'h41: res = mk_sym(3'd2, 5'b01000); // A .-
            8'h42: res = mk_sym(3'd4, 5'b10000); // B -...
            8'h43: res = mk_sym(3'd4, 5'b10100); // C -.-.
            8'h44: res = mk_sym(3'd3, 5'b10000); // D -..
            8'h45: res = mk_sym(3'd1, 5'b00000); // E .
            8'h46: res = mk_sym(3'd4, 5'b00100); // F ..-.
            8'h47: res = mk_sym(3'd3, 5'b11000); // G --.
            8'h48: res = mk_sym(3'd4, 5'b00000); // H ....
            8'h49: res = mk_sym(3'd2, 5'b00000); // I ..
            8'h4A: res = mk_sym(3'd4, 5'b01110); // J .---
            8'h4B: res = mk_sym(3'd3, 5'b10100); // K -.-
            8'h4C: res = mk_sym(3'd4, 5'b01000); // L .-..
            8'h4D: res = mk_sym(3'd2, 5'b11000); // M --
            8'h4E: res = mk_sym(3'd2, 5'b10000); // N -.
            8'h4F: res = mk_sym(3'd3, 5'b11100); // O ---
            8'h50: res = mk_sym(3'd4, 5'b01100); // P .--.
            8'h51: res = mk_sym(3'd4, 5'b11010); // Q --.-
            8'h52: res = mk_sym(3'd3, 5'b01000); // R .-.
            8'h53: res = mk_sym(3'd3, 5'b00000); // S ...
            8'h54: res = mk_sym(3'd1, 5'b10000); // T -
            8'h55: res = mk_sym(3'd3, 5'b00100); // U ..-
            8'h56: res = mk_sym(3'd4, 5'b00010); // V ...-
            8'h57: res = mk_sym(3'd3, 5'b01100); // W .--
            8'h58: res = mk_sym(3'd4, 5'b10010); // X -..-
            8'h59: res = mk_sym(3'd4, 5'b10110); // Y -.--
            8'h5A: res = mk_sym(3'd4, 5'b11000); // Z --..
            8'h30: res = mk_sym(3'd5, 5'b11111); // 0
            8'h31: res = mk_sym(3'd5, 5'b01111); // 1
            8'h32: res = mk_sym(3'd5, 5'b00111); // 2
            8'h33: res = mk_sym(3'd5, 5'b00011); // 3
            8'h34: res = mk_sym(3'd5, 5'b00001); // 4
            8'h35: res = mk_sym(3'd5, 5'b00000); // 5
            8'h36: res = mk_sym(3'd5, 5'b10000); // 6
            8'h37: res = mk_sym(3'd5, 5'b11000); // 7
            8'h38: res = mk_sym(3'd5, 5'b11100); // 8
            8'h39: res = mk_sym(3'd5, 5'b11110); // 9
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/morse_tx.sv
// Morse transmitter: snapshots an 8-character buffer on start and keys it
// out oldest-first (byte 7 .. byte 0) as on/off Morse timing.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   start    in   request transmission, sampled only in IDLE
//   buf_in   in   64-bit buffer, 8 x ASCII, 8'hFF = empty
//   key_out  out  registered key, 1 = tone on
//   busy     out  high in every state except IDLE
//   done     out  one-cycle completion pulse
//   char_idx out  byte index being sent (7 = oldest)
module morse_tx
    import morse_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES = 12_500_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] buf_in,
    output logic        key_out,
    output logic        busy,
    output logic        done,
    output logic [2:0]  char_idx
);

    localparam int unsigned TW = $clog2(7 * UNIT_CYCLES);

    state_t      state;
    logic [63:0] snap;
    logic [2:0]  idx;
    logic [TW-1:0] timer;
    logic [4:0]  pat;
    logic [2:0]  left;
    logic [7:0]  cur_byte;
    lut_res_t    lut;

    assign char_idx = idx;

    always_comb begin
        cur_byte = snap[idx*8 +: 8];
    end

    morse_lut u_lut (
        .ch  (cur_byte),
        .res (lut)
    );

    function automatic logic [TW-1:0] units(input int unsigned n);
        return TW'(n * UNIT_CYCLES - 1);
    endfunction

    // A gap followed by another FETCH ends one cycle early so the FETCH
    // cycle is absorbed into the gap and the off time stays n units.
    function automatic logic [TW-1:0] gap_units(input int unsigned n, input logic [2:0] i);
        return units(n) - TW'(i != 3'd0);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            snap    <= '1;
            idx     <= 3'd7;
            timer   <= '0;
            pat     <= '0;
            left    <= '0;
            key_out <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        snap  <= buf_in;
                        idx   <= 3'd7;
                        busy  <= 1'b1;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    if (lut.valid && lut.is_space) begin
                        timer <= gap_units(WGAP_UNITS, idx);
                        state <= WGAP;
                    end else if (lut.valid) begin
                        pat     <= lut.pattern << 1;
                        left    <= lut.len - 3'd1;
                        key_out <= 1'b1;
                        timer   <= units(lut.pattern[4] ? DASH_UNITS : DOT_UNITS);
                        state   <= MARK;
                    end else if (idx == 3'd0) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx - 3'd1;
                    end
                end
                MARK: begin
                    if (timer == '0) begin
                        key_out <= 1'b0;
                        if (left != 3'd0) begin
                            timer <= units(SGAP_UNITS);
                            state <= SGAP;
                        end else begin
                            timer <= gap_units(CGAP_UNITS, idx);
                            state <= CGAP;
                        end
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                SGAP: begin
                    if (timer == '0) begin
                        key_out <= 1'b1;
                        timer   <= units(pat[4] ? DASH_UNITS : DOT_UNITS);
                        pat     <= pat << 1;
                        left    <= left - 3'd1;
                        state   <= MARK;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                CGAP, WGAP: begin
                    if (timer == '0) begin
                        if (idx == 3'd0) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            idx   <= idx - 3'd1;
                            state <= FETCH;
                        end
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    idx   <= 3'd7;
                    state <= IDLE;
                end
                default: begin
                    key_out <= 1'b0;
                    busy    <= 1'b0;
                    idx     <= 3'd7;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_morse_tx.sv
// Testbench for morse_tx (UNIT_CYCLES = 4): directed and random buffers
// compared cycle by cycle against a timeline built from Morse code strings.
module tb_morse_tx;

    localparam int unsigned U = 4;
    localparam logic [2:0] SKIP = 3'd0;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] buf_in;
    logic        key_out;
    logic        busy;
    logic        done;
    logic [2:0]  char_idx;

    int n_cmp = 0;
    int n_bad = 0;

    bit       exp_key[$];
    bit       exp_idx_on[$];
    int       exp_idx[$];

    string letters[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                           "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                           "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                           "-.--", "--.."};
    string digits[10] = '{"-----", ".----", "..---", "...--", "....-",
                          ".....", "-....", "--...", "---..", "----."};

    always #5 clk = ~clk;

    morse_tx #(.UNIT_CYCLES(U)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .buf_in   (buf_in),
        .key_out  (key_out),
        .busy     (busy),
        .done     (done),
        .char_idx (char_idx)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic string morse_of(input logic [7:0] c);
        logic [7:0] u;
        u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
        if (u >= 8'h41 && u <= 8'h5A) return letters[u - 8'h41];
        if (u >= 8'h30 && u <= 8'h39) return digits[u - 8'h30];
        return "";
    endfunction

    task automatic push(input bit k, input bit on, input int i, input int unsigned n);
        for (int unsigned r = 0; r < n; r++) begin
            exp_key.push_back(k);
            exp_idx_on.push_back(on);
            exp_idx.push_back(i);
        end
    endtask

    // Timeline from the first cycle after start is sampled until just
    // before the done pulse. A gap that is not the last event swallows the
    // following byte's lookup cycle.
    task automatic build(input logic [63:0] b);
        bit absorbed;
        exp_key.delete();
        exp_idx_on.delete();
        exp_idx.delete();
        absorbed = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] c;
            string code;
            c = b[i*8 +: 8];
            code = morse_of(c);
            if (!absorbed) push(1'b0, 1'b1, i, 1);
            absorbed = 1'b0;
            if (c == 8'h20) begin
                push(1'b0, 1'b0, i, 4*U);
                absorbed = (i != 0);
            end else if (code.len() > 0) begin
                for (int j = 0; j < code.len(); j++) begin
                    push(1'b1, 1'b1, i, (code[j] == 8'h2D) ? 3*U : U);
                    if (j < code.len() - 1) push(1'b0, 1'b0, i, U);
                end
                push(1'b0, 1'b0, i, 3*U);
                absorbed = (i != 0);
            end
        end
    endtask

    task automatic run_tx(input logic [63:0] b, input bit disturb);
        build(b);
        @(negedge clk);
        buf_in = b;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        buf_in = {$urandom, $urandom};
        for (int k = 0; k < exp_key.size(); k++) begin
            if (k > 0) @(negedge clk);
            check("key", 32'(key_out), 32'(exp_key[k]));
            check("busy", 32'(busy), 32'd1);
            check("done_early", 32'(done), 32'd0);
            if (exp_idx_on[k]) check("char_idx", 32'(char_idx), exp_idx[k]);
            start = disturb ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
        @(negedge clk);
        start = 1'b0;
        check("done_pulse", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd1);
        check("done_key", 32'(key_out), 32'd0);
        check("done_idx", 32'(char_idx), 32'd0);
        @(negedge clk);
        check("idle_done", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_idx", 32'(char_idx), 32'd7);
        check("idle_key", 32'(key_out), 32'd0);
    endtask

    function automatic logic [7:0] rand_char();
        logic [7:0] odd[8];
        int unsigned r;
        odd = '{8'h21, 8'h3F, 8'h00, 8'h7F, 8'h40, 8'h5B, 8'h60, 8'h7B};
        r = $urandom_range(0, 9);
        case (r)
            0, 1:    return 8'hFF;
            2:       return 8'h20;
            3:       return odd[$urandom_range(0, 7)];
            4, 5:    return 8'(8'h41 + $urandom_range(0, 25));
            6:       return 8'(8'h61 + $urandom_range(0, 25));
            default: return 8'(8'h30 + $urandom_range(0, 9));
        endcase
    endfunction

    initial begin
        logic [63:0] directed[7];
        logic [63:0] rb;
        int seen;
        directed = '{64'hFFFF_FFFF_FFFF_FFFF,
                     64'hFFFF_FFFF_FFFF_FF45,
                     64'hFFFF_FFFF_FFFF_4554,
                     64'hFFFF_FFFF_FFFF_FF30,
                     64'hFFFF_FFFF_FF45_2045,
                     64'hFFFF_FFFF_FFFF_FF61,
                     64'h20FF_41FF_2020_215A};

        rst    = 1'b1;
        start  = 1'b0;
        buf_in = '1;
        #1;
        check("rst_key", 32'(key_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_idx", 32'(char_idx), 32'd7);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        foreach (directed[d]) run_tx(directed[d], 1'b0);
        run_tx(64'hFFFF_FFFF_FFFF_FF30, 1'b1);

        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < 8; i++) rb[i*8 +: 8] = rand_char();
            run_tx(rb, t[0]);
        end

        // Reset in the middle of a dash.
        @(negedge clk);
        buf_in = 64'h54FF_FFFF_FFFF_FFFF;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int w = 0; w < 20 && !key_out; w++) @(negedge clk);
        check("dash_key_up", 32'(key_out), 32'd1);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_key", 32'(key_out), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_idx", 32'(char_idx), 32'd7);
        @(negedge clk);
        rst = 1'b0;
        for (int w = 0; w < 30; w++) begin
            @(negedge clk);
            if (done) seen++;
            check("post_rst_key", 32'(key_out), 32'd0);
        end
        check("post_rst_done", 32'(seen), 32'd0);
        run_tx(64'hFFFF_FFFF_FFFF_4554, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
